reservation_station: RTL
========================

RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameter ENTRIES, default 4, meaning the number of station slots.
REQ-002 SHALL have parameter FULL_MARK, default 3, meaning the occupied-slot count at which rs_full asserts.
REQ-003 SHALL have port clk, input, width 1: the single clock; all state changes on posedge.
REQ-004 SHALL have port rst, input, width 1: asynchronous, active-low reset.
REQ-005 SHALL have port flush, input, width 1: synchronous clear of all slots.
REQ-006 SHALL have port op_in, input, width 5: dispatched opcode; 5'b11111 means no dispatch.
REQ-007 SHALL have ports value1_in and value2_in, input, width 32 each: operand values.
REQ-008 SHALL have ports query1_in and query2_in, input, width 3 each: producing ROB tag; 0 means the value is valid.
REQ-009 SHALL have port target_in, input, width 3: destination ROB index, 1..7.
REQ-010 SHALL have port imm_in, input, width 32: immediate, carried unchanged.
REQ-011 SHALL have ports alu_num and mem_num, input, width 3 each: broadcast tags; 0 means none.
REQ-012 SHALL have ports alu_value and mem_value, input, width 32 each: broadcast results.
REQ-013 SHALL have port rs_full, output, width 1: back-pressure to the dispatching ROB.
REQ-014 SHALL have port ex_op, output, width 5: issued opcode; 5'b11111 means idle.
REQ-015 SHALL have ports ex_a and ex_b, output, width 32 each: issued operand values.
REQ-016 SHALL have port ex_imm, output, width 32: issued immediate.
REQ-017 SHALL have port ex_tag, output, width 3: issued ROB index; 0 when idle.

Function
REQ-018 Each slot SHALL hold: busy, op, v1, v2, q1, q2, tag, imm.
REQ-019 A free slot SHALL accept a dispatch when op_in != 11111. The slot is the lowest-index non-busy slot. The dispatch is accepted even when rs_full=1 if a slot is free.
REQ-020 When op_in != 11111 and no slot is free, the dispatch SHALL be dropped. This is a protocol violation; the bench flags it.
REQ-021 At dispatch, an operand whose query matches a nonzero alu_num or mem_num in the same cycle SHALL capture the broadcast value, with q set to 0.
REQ-022 Every cycle, each busy slot whose q1 or q2 equals a nonzero alu_num or mem_num SHALL latch the matching value and clear that q.
REQ-023 If alu_num == mem_num != 0 in the same cycle, alu_value SHALL win.
REQ-024 Broadcasts with tag 0 SHALL be ignored.
REQ-025 A slot is ready when busy=1, q1=0 and q2=0, evaluated on the registered state at the clock edge.
REQ-026 Operands woken in the current cycle SHALL make the slot issuable the next cycle. Minimum dispatch-to-issue latency is 1 cycle when both operands are valid at dispatch.
REQ-027 Each cycle, at most one slot SHALL issue: the lowest-index ready slot. Its op, v1, v2, imm and tag are registered onto ex_op, ex_a, ex_b, ex_imm and ex_tag, and its busy is cleared in the same edge.
REQ-028 When no slot is ready, the block SHALL drive ex_op=11111 and ex_tag=0. ex_a, ex_b and ex_imm hold their prior values.
REQ-029 A slot freed by issue SHALL be reusable by a dispatch on the next edge, not the same edge.
REQ-030 rs_full SHALL be registered and equal (busy count after this edge's dispatch and issue) >= FULL_MARK.
REQ-031 The busy count SHALL saturate to the range 0..ENTRIES; dispatch and issue in the same edge SHALL leave the count unchanged.
REQ-032 flush=1 at a posedge SHALL clear all busy bits and drive ex_op=11111, ex_tag=0 and rs_full=0. Any simultaneous dispatch is discarded. flush has priority over wake-up and issue.

Reset
REQ-033 While rst=0, the block SHALL immediately and asynchronously clear all busy bits and all q fields, and drive rs_full=0, ex_op=11111, ex_a=0, ex_b=0, ex_imm=0 and ex_tag=0.
REQ-034 Reset asserted mid-operation SHALL discard all pending slots.
REQ-035 After rst deasserts, the first posedge SHALL accept a dispatch normally.

Verification
REQ-036 Ready dispatch: op=ADD(00000), q1=q2=0, v1=5, v2=7, target=3. Required: next edge ex_op=00000, ex_a=5, ex_b=7, ex_tag=3; the edge after, ex_op=11111.
REQ-037 Wake-up: dispatch SUB with q1=2, target=4. Two cycles later drive alu_num=2, alu_value=9. Required: issue one edge after the broadcast with ex_a=9, ex_tag=4.
REQ-038 Same-cycle capture: dispatch with q2=5 while mem_num=5, mem_value=0x1234. Required: the next edge issues with ex_b=0x1234.
REQ-039 Full and priority: dispatch 3 ops, each with q1=6, targets 1, 2, 3. Required: rs_full=1. Then broadcast alu_num=6. Required: issue order tags 1, 2, 3 on consecutive edges, and rs_full drops to 0 after the first issue.
REQ-040 Conflict: alu_num=mem_num=2 with alu_value=1 and mem_value=8 for a waiting q1=2. Required: ex_a=1.
REQ-041 Reset/flush: assert rst low between edges with 2 slots busy. Required: ex_op=11111 and rs_full=0 immediately, and no issue after release. Repeat with flush. Required: the same result on the next edge.

Source files
------------

// File: rtl/reservation_station_if.sv
// Dispatch, result-broadcast and issue signals of the reservation station.
// The master side is the dispatching ROB/broadcast source; the slave side is the station.
interface reservation_station_if;
  logic        flush;
  logic [4:0]  op_in;
  logic [31:0] value1_in;
  logic [31:0] value2_in;
  logic [2:0]  query1_in;
  logic [2:0]  query2_in;
  logic [2:0]  target_in;
  logic [31:0] imm_in;
  logic [2:0]  alu_num;
  logic [2:0]  mem_num;
  logic [31:0] alu_value;
  logic [31:0] mem_value;
  logic        rs_full;
  logic [4:0]  ex_op;
  logic [31:0] ex_a;
  logic [31:0] ex_b;
  logic [31:0] ex_imm;
  logic [2:0]  ex_tag;

  modport master (
    output flush, op_in, value1_in, value2_in, query1_in, query2_in, target_in, imm_in,
           alu_num, mem_num, alu_value, mem_value,
    input  rs_full, ex_op, ex_a, ex_b, ex_imm, ex_tag
  );

  modport slave (
    input  flush, op_in, value1_in, value2_in, query1_in, query2_in, target_in, imm_in,
           alu_num, mem_num, alu_value, mem_value,
    output rs_full, ex_op, ex_a, ex_b, ex_imm, ex_tag
  );
endinterface

// File: rtl/reservation_station.sv
// Reservation station: holds dispatched ops until both operands arrive via the
// ALU/memory result broadcasts, then issues the lowest-index ready slot each cycle.
module reservation_station #(
  parameter int ENTRIES   = 4,
  parameter int FULL_MARK = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  reservation_station_if.slave bus
);

  localparam logic [4:0] OP_NONE = 5'b11111;
  localparam int IW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
  localparam int CW = $clog2(ENTRIES + 1);

  logic [ENTRIES-1:0] busy;
  logic [4:0]         slot_op  [ENTRIES];
  logic [31:0]        slot_v1  [ENTRIES];
  logic [31:0]        slot_v2  [ENTRIES];
  logic [2:0]         slot_q1  [ENTRIES];
  logic [2:0]         slot_q2  [ENTRIES];
  logic [2:0]         slot_tag [ENTRIES];
  logic [31:0]        slot_imm [ENTRIES];

  logic        full_q;
  logic [4:0]  ex_op_q;
  logic [31:0] ex_a_q;
  logic [31:0] ex_b_q;
  logic [31:0] ex_imm_q;
  logic [2:0]  ex_tag_q;

  logic [ENTRIES-1:0] busy_next;
  logic [IW-1:0]      issue_idx;
  logic [IW-1:0]      free_idx;
  logic               issue_valid;
  logic               free_valid;
  logic               dispatch;
  logic [CW-1:0]      next_count;

  // Returns {q, v} after snooping both result buses; ALU wins a same-tag tie.
  function automatic logic [34:0] snoop(input logic [2:0] q, input logic [31:0] v,
                                        input logic [2:0] an, input logic [31:0] av,
                                        input logic [2:0] mn, input logic [31:0] mv);
    if (q != 3'd0 && q == an) return {3'd0, av};
    if (q != 3'd0 && q == mn) return {3'd0, mv};
    return {q, v};
  endfunction

  // Descending scan leaves the lowest matching index in each select.
  always_comb begin
    issue_valid = 1'b0;
    issue_idx   = '0;
    free_valid  = 1'b0;
    free_idx    = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (busy[i] && slot_q1[i] == 3'd0 && slot_q2[i] == 3'd0) begin
        issue_valid = 1'b1;
        issue_idx   = IW'(i);
      end
      if (!busy[i]) begin
        free_valid = 1'b1;
        free_idx   = IW'(i);
      end
    end
    dispatch  = (bus.op_in != OP_NONE) && free_valid;
    busy_next = busy;
    if (issue_valid) busy_next[issue_idx] = 1'b0;
    if (dispatch)    busy_next[free_idx]  = 1'b1;
    next_count = '0;
    for (int i = 0; i < ENTRIES; i++) next_count = next_count + CW'(busy_next[i]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= '0;
      full_q   <= 1'b0;
      ex_op_q  <= OP_NONE;
      ex_a_q   <= '0;
      ex_b_q   <= '0;
      ex_imm_q <= '0;
      ex_tag_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        slot_op[i]  <= OP_NONE;
        slot_v1[i]  <= '0;
        slot_v2[i]  <= '0;
        slot_q1[i]  <= '0;
        slot_q2[i]  <= '0;
        slot_tag[i] <= '0;
        slot_imm[i] <= '0;
      end
    end else if (bus.flush) begin
      busy     <= '0;
      full_q   <= 1'b0;
      ex_op_q  <= OP_NONE;
      ex_tag_q <= '0;
    end else begin
      busy   <= busy_next;
      full_q <= (int'(next_count) >= FULL_MARK);
      for (int i = 0; i < ENTRIES; i++) begin
        if (busy[i]) begin
          {slot_q1[i], slot_v1[i]} <= snoop(slot_q1[i], slot_v1[i], bus.alu_num, bus.alu_value,
                                            bus.mem_num, bus.mem_value);
          {slot_q2[i], slot_v2[i]} <= snoop(slot_q2[i], slot_v2[i], bus.alu_num, bus.alu_value,
                                            bus.mem_num, bus.mem_value);
        end
      end
      // The free slot is never busy, so the dispatch write cannot collide with wake-up.
      if (dispatch) begin
        slot_op[free_idx]  <= bus.op_in;
        slot_tag[free_idx] <= bus.target_in;
        slot_imm[free_idx] <= bus.imm_in;
        {slot_q1[free_idx], slot_v1[free_idx]} <= snoop(bus.query1_in, bus.value1_in,
            bus.alu_num, bus.alu_value, bus.mem_num, bus.mem_value);
        {slot_q2[free_idx], slot_v2[free_idx]} <= snoop(bus.query2_in, bus.value2_in,
            bus.alu_num, bus.alu_value, bus.mem_num, bus.mem_value);
      end
      if (issue_valid) begin
        ex_op_q  <= slot_op[issue_idx];
        ex_a_q   <= slot_v1[issue_idx];
        ex_b_q   <= slot_v2[issue_idx];
        ex_imm_q <= slot_imm[issue_idx];
        ex_tag_q <= slot_tag[issue_idx];
      end else begin
        ex_op_q  <= OP_NONE;
        ex_tag_q <= '0;
      end
    end
  end

  assign bus.rs_full = full_q;
  assign bus.ex_op   = ex_op_q;
  assign bus.ex_a    = ex_a_q;
  assign bus.ex_b    = ex_b_q;
  assign bus.ex_imm  = ex_imm_q;
  assign bus.ex_tag  = ex_tag_q;

endmodule
